// File: rtl/elastic_skid_fifo.sv
// Elastic valid/busy buffer: registered head word plus a circular RAM behind it.
// Busy, valid, data, occupancy and almost-full are all driven from flops.
module elastic_skid_fifo #(
  parameter int D_W      = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       i_v,
  input  logic [D_W-1:0]             i_d,
  output logic                       i_b,
  output logic                       o_v,
  output logic [D_W-1:0]             o_d,
  input  logic                       o_b,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int RAM_D = DEPTH - 1;
  localparam int PW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RAM_D - 1);

  logic [D_W-1:0] ram [RAM_D];

  logic           o_v_q, o_v_d;
  logic [D_W-1:0] o_d_q, o_d_d;
  logic           i_b_q, i_b_d;
  logic           af_q, af_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;

  logic push, pop, ram_empty, load_out, ram_we;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push      = i_v & ~i_b_q;
    pop       = o_v_q & ~o_b;
    // RAM occupancy is total occupancy minus the head word
    ram_empty = (count_q == CW'(o_v_q));
    load_out  = ~o_v_q | pop;
    ram_we    = push & ~(load_out & ram_empty) & ~flush & ~rst;

    o_v_d    = o_v_q;
    o_d_d    = o_d_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (load_out) begin
      if (!ram_empty) begin
        o_v_d    = 1'b1;
        o_d_d    = ram[rd_ptr_q];
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (push) begin
        o_v_d = 1'b1;
        o_d_d = i_d;
      end else begin
        o_v_d = 1'b0;
      end
    end
    if (ram_we) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    count_d = count_q + CW'(push) - CW'(pop);
    i_b_d   = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(AF_LEVEL));

    if (flush) begin
      o_v_d    = 1'b0;
      count_d  = '0;
      i_b_d    = 1'b0;
      af_d     = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_v_q    <= 1'b0;
      o_d_q    <= '0;
      i_b_q    <= 1'b0;
      af_q     <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      o_v_q    <= o_v_d;
      o_d_q    <= o_d_d;
      i_b_q    <= i_b_d;
      af_q     <= af_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[wr_ptr_q] <= i_d;
    end
  end

  assign i_b         = i_b_q;
  assign o_v         = o_v_q;
  assign o_d         = o_d_q;
  assign count       = count_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_elastic_skid_fifo.sv
// Directed and randomised checks for elastic_skid_fifo (DEPTH=4, AF_LEVEL=3).
module tb_elastic_skid_fifo;

  localparam int D_W   = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic           clk = 1'b0;
  logic           rst, flush, i_v, i_b, o_v, o_b, almost_full;
  logic [D_W-1:0] i_d, o_d;
  logic [2:0]     count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elastic_skid_fifo #(.D_W(D_W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_v(i_v), .i_d(i_d), .i_b(i_b),
    .o_v(o_v), .o_d(o_d), .o_b(o_b),
    .count(count), .almost_full(almost_full)
  );

  // Drive one cycle of inputs, clock once, and leave the bench 1 time unit past the edge.
  task automatic tick(input logic iv, input logic [D_W-1:0] d, input logic ob, input logic fl);
    i_v = iv; i_d = d; o_b = ob; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    n_vec += 5;
    if (o_v !== 1'b0) begin n_err++; $display("FAIL reset_ov got=%0b exp=0", o_v); end
    if (o_d !== 32'h0) begin n_err++; $display("FAIL reset_od got=%h exp=0", o_d); end
    if (i_b !== 1'b0) begin n_err++; $display("FAIL reset_ib got=%0b exp=0", i_b); end
    if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    tick(1'b1, 32'hA5, 1'b0, 1'b0);
    n_vec += 3;
    if (o_v !== 1'b1) begin n_err++; $display("FAIL single_ov got=%0b exp=1", o_v); end
    if (o_d !== 32'hA5) begin n_err++; $display("FAIL single_od got=%h exp=a5", o_d); end
    if (count !== 3'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", count); end
    tick(1'b0, '0, 1'b0, 1'b0);
    n_vec += 2;
    if (o_v !== 1'b0) begin n_err++; $display("FAIL single_pop_ov got=%0b exp=0", o_v); end
    if (count !== 3'd0) begin n_err++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    $display("test_single done");
  endtask

  task automatic test_fill_stall();
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_af  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_ib  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, D_W'(k + 1), 1'b1, 1'b0);
      n_vec += 5;
      if (count !== exp_cnt[k]) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", k, count, exp_cnt[k]); end
      if (almost_full !== exp_af[k]) begin n_err++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", k, almost_full, exp_af[k]); end
      if (i_b !== exp_ib[k]) begin n_err++; $display("FAIL fill_ib[%0d] got=%0b exp=%0b", k, i_b, exp_ib[k]); end
      if (o_v !== 1'b1) begin n_err++; $display("FAIL fill_ov[%0d] got=%0b exp=1", k, o_v); end
      if (o_d !== 32'h1) begin n_err++; $display("FAIL fill_od[%0d] got=%h exp=1", k, o_d); end
    end
    $display("test_fill_stall done");
  endtask

  task automatic test_drain();
    logic [2:0]     exp_cnt [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic [D_W-1:0] exp_od  [3] = '{32'h2, 32'h3, 32'h4};
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      n_vec += 3;
      if (count !== exp_cnt[k]) begin n_err++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, count, exp_cnt[k]); end
      if (i_b !== 1'b0) begin n_err++; $display("FAIL drain_ib[%0d] got=%0b exp=0", k, i_b); end
      if (k < 3) begin
        if (o_v !== 1'b1 || o_d !== exp_od[k]) begin
          n_err++; $display("FAIL drain_word[%0d] got v=%0b d=%h exp v=1 d=%h", k, o_v, o_d, exp_od[k]);
        end
      end else if (o_v !== 1'b0) begin
        n_err++; $display("FAIL drain_empty got=%0b exp=0", o_v);
      end
    end
    $display("test_drain done");
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    for (int c = 0; c < 80 && popped < 3 * DEPTH; c++) begin
      logic           ob = (c % 3 == 0);
      logic           iv = (pushed < 3 * DEPTH);
      logic [D_W-1:0] d  = 32'h100 + D_W'(pushed);
      if (o_v && !ob) begin
        n_vec++;
        if (o_d !== 32'h100 + D_W'(popped)) begin
          n_err++; $display("FAIL wrap_order[%0d] got=%h exp=%h", popped, o_d, 32'h100 + D_W'(popped));
        end
        popped++;
      end
      if (iv && !i_b) pushed++;
      tick(iv, d, ob, 1'b0);
    end
    n_vec += 2;
    if (popped != 3 * DEPTH) begin n_err++; $display("FAIL wrap_popped got=%0d exp=%0d", popped, 3 * DEPTH); end
    if (count !== 3'd0) begin n_err++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
    $display("test_wrap done");
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 32'h200 + D_W'(k), 1'b0, 1'b0);
      n_vec += 3;
      if (o_v !== 1'b1 || o_d !== 32'h200 + D_W'(k)) begin
        n_err++; $display("FAIL stream_word[%0d] got v=%0b d=%h exp v=1 d=%h", k, o_v, o_d, 32'h200 + D_W'(k));
      end
      if (count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
      if (i_b !== 1'b0) begin n_err++; $display("FAIL stream_ib[%0d] got=%0b exp=0", k, i_b); end
    end
    tick(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (count !== 3'd0) begin n_err++; $display("FAIL stream_end_count got=%0d exp=0", count); end
    $display("test_stream done");
  endtask

  task automatic test_random();
    logic [D_W-1:0] mq [$];
    for (int c = 0; c < 10000; c++) begin
      int             bias = ((c / 500) % 2 == 1) ? 75 : 25;
      logic           iv   = ($urandom_range(0, 99) < 70);
      logic           ob   = ($urandom_range(0, 99) < bias);
      logic           fl   = ($urandom_range(0, 199) == 0);
      logic [D_W-1:0] d    = $urandom;
      logic           push = iv && (mq.size() != DEPTH);
      logic           pop  = (mq.size() != 0) && !ob;
      tick(iv, d, ob, fl);
      if (fl) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
      end
      n_vec += 4;
      if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, count, mq.size()); end
      if (o_v !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_ov[%0d] got=%0b exp=%0b", c, o_v, mq.size() != 0); end
      if (i_b !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rand_ib[%0d] got=%0b exp=%0b", c, i_b, mq.size() == DEPTH); end
      if (almost_full !== (mq.size() >= AF)) begin n_err++; $display("FAIL rand_af[%0d] got=%0b exp=%0b", c, almost_full, mq.size() >= AF); end
      if (mq.size() != 0) begin
        n_vec++;
        if (o_d !== mq[0]) begin n_err++; $display("FAIL rand_od[%0d] got=%h exp=%h", c, o_d, mq[0]); end
      end
    end
    $display("test_random done");
  endtask

  task automatic test_flush();
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 32'hC1, 1'b1, 1'b0);
    tick(1'b1, 32'hC2, 1'b1, 1'b0);
    tick(1'b1, 32'hC3, 1'b1, 1'b0);
    n_vec += 2;
    if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    if (almost_full !== 1'b1) begin n_err++; $display("FAIL flush_pre_af got=%0b exp=1", almost_full); end
    tick(1'b1, 32'hFF, 1'b1, 1'b1);
    n_vec += 4;
    if (o_v !== 1'b0) begin n_err++; $display("FAIL flush_ov got=%0b exp=0", o_v); end
    if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (i_b !== 1'b0) begin n_err++; $display("FAIL flush_ib got=%0b exp=0", i_b); end
    if (almost_full !== 1'b0) begin n_err++; $display("FAIL flush_af got=%0b exp=0", almost_full); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if (o_v !== 1'b0) begin n_err++; $display("FAIL flush_ghost[%0d] got v=%0b d=%h exp v=0", k, o_v, o_d); end
    end
    tick(1'b1, 32'hD1, 1'b1, 1'b0);
    n_vec += 2;
    if (o_v !== 1'b1 || o_d !== 32'hD1) begin n_err++; $display("FAIL flush_after got v=%0b d=%h exp v=1 d=d1", o_v, o_d); end
    if (count !== 3'd1) begin n_err++; $display("FAIL flush_after_count got=%0d exp=1", count); end
    tick(1'b0, '0, 1'b0, 1'b0);
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 32'hE1, 1'b1, 1'b0);
    tick(1'b1, 32'hE2, 1'b1, 1'b0);
    tick(1'b1, 32'hE3, 1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 32'hEE, 1'b1, 1'b1);
    rst = 1'b0;
    n_vec += 5;
    if (o_v !== 1'b0) begin n_err++; $display("FAIL rstmid_ov got=%0b exp=0", o_v); end
    if (o_d !== 32'h0) begin n_err++; $display("FAIL rstmid_od got=%h exp=0", o_d); end
    if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    if (i_b !== 1'b0) begin n_err++; $display("FAIL rstmid_ib got=%0b exp=0", i_b); end
    if (almost_full !== 1'b0) begin n_err++; $display("FAIL rstmid_af got=%0b exp=0", almost_full); end
    tick(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (o_v !== 1'b0) begin n_err++; $display("FAIL rstmid_ghost got v=%0b d=%h exp v=0", o_v, o_d); end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; i_v = 1'b0; i_d = '0; o_b = 1'b0;
    test_reset();
    test_single();
    test_fill_stall();
    test_drain();
    test_wrap();
    test_stream();
    test_random();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
